stream_bit_reversal: RTL and testbench

STREAM_BIT_REVERSAL -- requirements
Module: stream_bit_reversal

---
 rtl/stream_bit_reversal.sv | 109 ++++++++++
 tb/tb_stream_bit_reversal.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bit_reversal.sv
// Ping-pong frame buffer that emits each N-element frame in bit-reversed (or natural) order.
// Output starts the cycle after a frame's last beat; s_ready drops only while the write bank is still FULL.
module stream_bit_reversal #(
  parameter int LOG_N = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     cfg_enable,
  input  logic [$clog2(LOG_N)-1:0] cfg_depth,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_last
);

  localparam int N  = 1 << LOG_N;
  localparam int DW = $clog2(LOG_N);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [WIDTH-1:0] mem [2][N];
  logic [1:0]       bank_st   [2];
  logic             cfg_en_q  [2];
  logic [DW-1:0]    cfg_dep_q [2];

  logic             wr_bank;
  logic             rd_bank;
  logic [LOG_N-1:0] wr_cnt;
  logic [LOG_N-1:0] rd_cnt;
  logic [LOG_N-1:0] rd_addr;
  logic [DW-1:0]    dep_clamped;
  logic             s_fire;
  logic             m_fire;

  // Both ready and valid come from registered bank state, so a bank freed by the
  // final read only becomes writable on the next cycle.
  assign s_ready = (bank_st[wr_bank] != ST_FULL);
  assign m_valid = (bank_st[rd_bank] == ST_FULL);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  assign dep_clamped = (int'(cfg_depth) >= LOG_N) ? DW'(LOG_N - 1) : cfg_depth;

  // Address bits 0..depth are mirrored around depth/2; bits above depth pass through.
  always_comb begin
    rd_addr = rd_cnt;
    if (cfg_en_q[rd_bank]) begin
      for (int i = 0; i < LOG_N; i++) begin
        if (DW'(i) <= cfg_dep_q[rd_bank]) begin
          rd_addr[i] = rd_cnt[cfg_dep_q[rd_bank] - DW'(i)];
        end
      end
    end
  end

  assign m_data = m_valid ? mem[rd_bank][rd_addr] : '0;
  assign m_last = m_valid && (rd_cnt == '1);

  always_ff @(posedge clk) begin
    if (s_fire) begin
      mem[wr_bank][wr_cnt] <= s_data;
    end
  end

  // Write and read sides never touch the same bank's state in one cycle:
  // writes need a non-FULL bank, reads need a FULL one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]   <= ST_EMPTY;
      bank_st[1]   <= ST_EMPTY;
      cfg_en_q[0]  <= 1'b0;
      cfg_en_q[1]  <= 1'b0;
      cfg_dep_q[0] <= '0;
      cfg_dep_q[1] <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
    end else begin
      if (s_fire) begin
        wr_cnt <= wr_cnt + LOG_N'(1);
        if (wr_cnt == '0) begin
          cfg_en_q[wr_bank]  <= cfg_enable;
          cfg_dep_q[wr_bank] <= dep_clamped;
        end
        if (wr_cnt == '1) begin
          bank_st[wr_bank] <= ST_FULL;
          wr_bank          <= ~wr_bank;
        end else begin
          bank_st[wr_bank] <= ST_FILLING;
        end
      end
      if (m_fire) begin
        rd_cnt <= rd_cnt + LOG_N'(1);
        if (rd_cnt == '1) begin
          bank_st[rd_bank] <= ST_EMPTY;
          rd_bank          <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_bit_reversal.sv
// Bench for stream_bit_reversal: frame-level reference model plus directed literal checks.
module tb_stream_bit_reversal;
  localparam int LOG_N = 8;
  localparam int N     = 256;
  localparam int W     = 32;
  localparam int DW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          s_valid, s_ready, cfg_enable;
  logic [W-1:0]  s_data;
  logic [DW-1:0] cfg_depth;
  logic          m_valid, m_ready, m_last;
  logic [W-1:0]  m_data;

  logic          s2_valid, s2_ready, s2_en, m2_valid, m2_ready, m2_last;
  logic [7:0]    s2_data, m2_data;
  logic [2:0]    s2_depth;

  stream_bit_reversal #(.LOG_N(LOG_N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_enable(cfg_enable), .cfg_depth(cfg_depth),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // Small instance where a 3-bit depth can exceed LOG_N-1, to exercise clamping.
  stream_bit_reversal #(.LOG_N(5), .WIDTH(8)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
    .cfg_enable(s2_en), .cfg_depth(s2_depth),
    .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data), .m_last(m2_last)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Index within the frame that output position k reads from.
  function automatic int perm(input int k, input bit en, input int dep);
    int mask, rev;
    if (!en) return k;
    mask = (1 << (dep + 1)) - 1;
    rev  = 0;
    for (int b = 0; b <= dep; b++)
      if (((k >> b) & 1) != 0) rev |= 1 << (dep - b);
    return (k & ~mask) | rev;
  endfunction

  logic [W-1:0] fbuf [N];
  int           fcnt = 0;
  bit           fen;
  int           fdep;
  logic [W-1:0] exp_d [$];
  bit           exp_l [$];
  logic [W-1:0] out_log [$];
  int           out_cyc [$];
  int           sr_drop = 0;
  bit           watch_sr = 0;
  int           pending;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_d.delete();
      exp_l.delete();
      fcnt = 0;
    end else begin
      pending = (exp_d.size() + N - 1) / N;
      check("s_ready", s_ready, pending < 2);
      if (exp_d.size() > 0) begin
        check("m_valid", m_valid, 1'b1);
        check("m_data", m_data, exp_d[0]);
        check("m_last", m_last, exp_l[0]);
        if (m_valid && m_ready) begin
          out_log.push_back(m_data);
          out_cyc.push_back(cyc);
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
      end else begin
        check("m_valid_idle", m_valid, 1'b0);
        check("m_data_idle", m_data, '0);
        check("m_last_idle", m_last, 1'b0);
      end
      if (watch_sr && s_valid && !s_ready) sr_drop++;
      if (s_valid && s_ready) begin
        if (fcnt == 0) begin
          fen  = cfg_enable;
          fdep = (int'(cfg_depth) >= LOG_N) ? LOG_N - 1 : int'(cfg_depth);
        end
        fbuf[fcnt] = s_data;
        fcnt++;
        if (fcnt == N) begin
          for (int k = 0; k < N; k++) begin
            exp_d.push_back(fbuf[perm(k, fen, fdep)]);
            exp_l.push_back(k == N - 1);
          end
          fcnt = 0;
        end
      end
    end
  end

  bit rnd_rdy  = 0;
  bit hold_rdy = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
    end
  end

  task automatic drive_beat();
    bit ok = 0;
    s_valid = 1'b1;
    for (int t = 0; t < 4000 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) timeout_fail("beat_accept");
  endtask

  // mode 0: ramp data, fixed cfg; mode 1: random data, gaps, cfg churn; mode 2: ramp data, cfg churn.
  task automatic send_frame(input bit en, input int dep, input int mode, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_data = (mode == 1) ? W'($urandom) : W'(k);
      if (k == 0) begin
        cfg_enable = en;
        cfg_depth  = DW'(dep);
      end else if (mode != 0) begin
        cfg_enable = 1'($urandom_range(0, 1));
        cfg_depth  = DW'($urandom_range(0, 7));
      end
      drive_beat();
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 6000 && !done; t++) begin
      @(negedge clk);
      done = (exp_d.size() == 0) && (fcnt == 0);
    end
    @(posedge clk);
    #1;
    if (!done) timeout_fail("drain");
  endtask

  task automatic small_test();
    int  got = 0;
    bit  ok;
    s2_en    = 1'b1;
    s2_depth = 3'd7;
    m2_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      s2_data  = 8'(k);
      s2_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        ok = s2_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) timeout_fail("small_accept");
    end
    s2_valid = 1'b0;
    m2_ready = 1'b1;
    for (int t = 0; t < 200 && got < 32; t++) begin
      @(negedge clk);
      if (m2_valid) begin
        // depth 7 clamps to 4: a full 5-bit reversal
        check("small_data", m2_data, 8'(perm(got, 1'b1, 4)));
        check("small_last", m2_last, got == 31);
        if (got == 1) check("small_lit1", m2_data, 8'd16);
        if (got == 3) check("small_lit3", m2_data, 8'd24);
        got++;
      end
      @(posedge clk);
      #1;
    end
    if (got != 32) timeout_fail("small_drain");
    m2_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base, d0;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; cfg_enable = 1'b0; cfg_depth = '0;
    s2_valid = 1'b0; s2_data = '0; s2_en = 1'b0; s2_depth = '0; m2_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back: full reversal then natural order, m_ready high.
    hold_rdy = 1;
    @(posedge clk);
    #1;
    base = out_log.size();
    d0 = sr_drop;
    watch_sr = 1;
    send_frame(1'b1, 7, 0, N);
    send_frame(1'b0, 0, 0, N);
    s_valid = 1'b0;
    watch_sr = 0;
    drain();
    check("b2b_sready_drop", sr_drop - d0, 0);
    check("b2b_count", out_log.size() - base, 512);
    if (out_log.size() - base == 512) begin
      check("b2b_contiguous", out_cyc[base + 511] - out_cyc[base], 511);
      check("rev_lit1", out_log[base + 1], 128);
      check("rev_lit2", out_log[base + 2], 64);
      check("rev_lit3", out_log[base + 3], 192);
      check("rev_lit4", out_log[base + 4], 32);
      check("rev_lit255", out_log[base + 255], 255);
      check("nat_lit5", out_log[base + 261], 5);
    end

    // Depth 1 swaps address bits 0 and 1 only.
    base = out_log.size();
    send_frame(1'b1, 1, 0, N);
    s_valid = 1'b0;
    drain();
    check("d1_count", out_log.size() - base, 256);
    if (out_log.size() - base == 256) begin
      check("d1_lit1", out_log[base + 1], 2);
      check("d1_lit2", out_log[base + 2], 1);
      check("d1_lit6", out_log[base + 6], 5);
      check("d1_lit7", out_log[base + 7], 7);
    end

    // Random traffic, random backpressure, cfg churn mid-frame.
    rnd_rdy = 1;
    base = out_log.size();
    for (int f = 0; f < 4; f++)
      send_frame(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1, N);
    s_valid = 1'b0;
    drain();
    rnd_rdy = 0;
    check("rand_count", out_log.size() - base, 1024);

    // Beat-0 config (depth 3) must survive cfg changes later in the frame.
    base = out_log.size();
    send_frame(1'b1, 3, 2, N);
    s_valid = 1'b0;
    drain();
    check("midcfg_count", out_log.size() - base, 256);
    if (out_log.size() - base == 256) begin
      check("midcfg_lit1", out_log[base + 1], 8);
      check("midcfg_lit2", out_log[base + 2], 4);
      check("midcfg_lit16", out_log[base + 16], 16);
    end

    small_test();

    // Reset with one frame buffered and the next 100 beats in.
    hold_rdy = 0;
    @(posedge clk);
    #1;
    send_frame(1'b1, 7, 0, N);
    send_frame(1'b1, 7, 0, 100);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_s_ready", s_ready, 1'b1);
    check("midrst_m_data", m_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_rdy = 1;
    base = out_log.size();
    send_frame(1'b1, 7, 0, N);
    s_valid = 1'b0;
    drain();
    check("post_rst_count", out_log.size() - base, 256);
    if (out_log.size() - base == 256) begin
      check("post_rst_lit0", out_log[base], 0);
      check("post_rst_lit1", out_log[base + 1], 128);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
